// File: rtl/fetch_pkg.sv
// Shared types and constants for the ROM fetch stage: FSM state encoding,
// default widths, the halt opcode and instruction-field helpers.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 4;
  localparam int FETCH_DATA_W = 8;
  localparam int OPC_W        = 4;
  localparam int OPD_W        = 4;

  localparam logic [OPC_W-1:0]        FETCH_HLT_OPC  = 4'hF;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 4'h0;

  typedef enum logic [2:0] {
    F_ADDR = 3'd0,
    F_READ = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    M_ADDR = 3'd4,
    M_READ = 3'd5,
    HALT   = 3'd6
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [FETCH_DATA_W-1:0] word);
    return word[FETCH_DATA_W-1 -: OPC_W];
  endfunction

  function automatic logic [OPD_W-1:0] operand_of(input logic [FETCH_DATA_W-1:0] word);
    return word[OPD_W-1:0];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: increments by one with natural wrap, or loads a jump
// target; load takes priority over increment.
module pc_counter #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              low_rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // next program counter value
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // program counter register
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage in front of a 16x8 ROM: owns PC/MAR, fetches into the IR, issues
// opcode/operand over valid/ready and serves operand reads while executing.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter logic [OPC_W-1:0]  HLT_OPC  = FETCH_HLT_OPC,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              low_rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              low_rom_o_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [OPC_W-1:0]  ir_opcode,
  output logic [OPD_W-1:0]  ir_operand,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_data,
  input  logic              exec_done,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              low_rom_o_en_q, low_rom_o_en_d;
  logic              ir_valid_q, ir_valid_d;
  logic              mem_ack_q, mem_ack_d;
  logic              halted_q, halted_d;
  logic              pc_inc_s, pc_load_s;
  logic [ADDR_W-1:0] pc_s;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .low_rst   (low_rst),
    .inc       (pc_inc_s),
    .load      (pc_load_s),
    .load_addr (jmp_addr),
    .pc        (pc_s)
  );

  // state register
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      state_q <= F_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; exec_done outranks a simultaneous mem_req
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_ADDR: state_d = F_READ;
      F_READ: begin
        if (opcode_of(rom_data) == HLT_OPC) begin
          state_d = HALT;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ir_ready) begin
          state_d = EXEC;
        end else begin
          state_d = ISSUE;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_d = F_ADDR;
        end else if (mem_req) begin
          state_d = M_ADDR;
        end else begin
          state_d = EXEC;
        end
      end
      M_ADDR:  state_d = M_READ;
      M_READ:  state_d = EXEC;
      HALT:    state_d = HALT;
      default: state_d = F_ADDR;
    endcase
  end

  // datapath: MAR, IR, operand data and PC controls
  always_comb begin
    mar_d      = mar_q;
    ir_d       = ir_q;
    mem_data_d = mem_data_q;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    case (state_q)
      F_ADDR: mar_d = pc_s;
      F_READ: begin
        ir_d     = rom_data;
        pc_inc_s = 1'b1;
      end
      EXEC: begin
        if (exec_done) begin
          pc_load_s = jmp_en;
        end else if (mem_req) begin
          mar_d = mem_addr;
        end else begin
          mar_d = mar_q;
        end
      end
      M_READ:  mem_data_d = rom_data;
      default: mar_d = mar_q;
    endcase
  end

  // output decode, registered from the state being entered
  always_comb begin
    low_rom_o_en_d = 1'b1;
    ir_valid_d     = 1'b0;
    halted_d       = 1'b0;
    mem_ack_d      = 1'b0;
    case (state_d)
      F_READ:  low_rom_o_en_d = 1'b0;
      M_READ:  low_rom_o_en_d = 1'b0;
      ISSUE:   ir_valid_d     = 1'b1;
      HALT:    halted_d       = 1'b1;
      default: low_rom_o_en_d = 1'b1;
    endcase
    if (state_q == M_READ) begin
      mem_ack_d = 1'b1;
    end else begin
      mem_ack_d = 1'b0;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      mar_q          <= {ADDR_W{1'b0}};
      ir_q           <= {DATA_W{1'b0}};
      mem_data_q     <= {DATA_W{1'b0}};
      low_rom_o_en_q <= 1'b1;
      ir_valid_q     <= 1'b0;
      mem_ack_q      <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      mar_q          <= mar_d;
      ir_q           <= ir_d;
      mem_data_q     <= mem_data_d;
      low_rom_o_en_q <= low_rom_o_en_d;
      ir_valid_q     <= ir_valid_d;
      mem_ack_q      <= mem_ack_d;
      halted_q       <= halted_d;
    end
  end

  assign rom_addr     = mar_q;
  assign low_rom_o_en = low_rom_o_en_q;
  assign ir_valid     = ir_valid_q;
  assign ir_opcode    = opcode_of(ir_q);
  assign ir_operand   = operand_of(ir_q);
  assign mem_ack      = mem_ack_q;
  assign mem_data     = mem_data_q;
  assign pc           = pc_s;
  assign halted       = halted_q;

endmodule
